// File: rtl/cv32e40p_pdl_pkg.sv
// Shared defaults and helpers for the propagation-delay-line glitch monitor.
package cv32e40p_pdl_pkg;

    localparam int unsigned PDL_NUM_CH       = 4;
    localparam int unsigned PDL_THRESH       = 2;
    localparam int unsigned PDL_BLANK_CYCLES = 4;
    localparam int unsigned PDL_CNT_W        = 8;

    // Increment that holds at max instead of wrapping; callers cast back to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
        return (cnt >= max) ? max : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/cv32e40p_PDL_buffer.sv
// Behavioural stand-in for the hard delay-line cell; in silicon this is a tuned buffer chain.
module cv32e40p_PDL_buffer (
    input  logic clk,
    input  logic i_buf,
    output logic o_buf
);

    // clk kept only for pin compatibility with the physical cell
    logic unused_clk;
    assign unused_clk = clk;

    // Nominal-clock view: the chain settles well within one period
    assign o_buf = i_buf;

endmodule

// File: rtl/cv32e40p_pdl_channel.sv
// One monitor channel: toggle flop, delay line, direct/delayed sample pair and run filter.
module cv32e40p_pdl_channel
    import cv32e40p_pdl_pkg::*;
#(
    parameter int unsigned THRESH = PDL_THRESH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic blank_done_i,
    output logic toggle_o,
    output logic delay_line_o,
    output logic mis_c_o,
    output logic set_c_o
);

    localparam int unsigned RUN_W = $clog2(THRESH + 1);

    logic             tog_q, tog_d;
    logic             dly_q, dly_d;
    logic             dir_q, dir_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             qual;

    cv32e40p_PDL_buffer u_pdl_buf (
        .clk   (clk),
        .i_buf (tog_q),
        .o_buf (delay_line_o)
    );

    // Toggle/sample next state, mismatch qualification and consecutive-run filter
    always_comb begin
        tog_d   = ~tog_q;
        dly_d   = delay_line_o;
        dir_d   = tog_q;
        mis_c_o = dly_q ^ dir_q;
        qual    = mis_c_o & en_i & blank_done_i;
        run_d   = '0;
        if (qual) begin
            run_d = RUN_W'(sat_inc(32'(run_q), 32'(THRESH)));
        end
        set_c_o = qual & (run_q == RUN_W'(THRESH - 1));
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tog_q <= 1'b0;
            dly_q <= 1'b0;
            dir_q <= 1'b0;
            run_q <= '0;
        end else begin
            tog_q <= tog_d;
            dly_q <= dly_d;
            dir_q <= dir_d;
            run_q <= run_d;
        end
    end

    assign toggle_o = tog_q;

endmodule

// File: rtl/cv32e40p_pdl_monitor.sv
// Multi-channel clock-glitch monitor: blanking, sticky per-channel alarms and event counter.
module cv32e40p_pdl_monitor
    import cv32e40p_pdl_pkg::*;
#(
    parameter int unsigned NUM_CH       = PDL_NUM_CH,
    parameter int unsigned THRESH       = PDL_THRESH,
    parameter int unsigned BLANK_CYCLES = PDL_BLANK_CYCLES,
    parameter int unsigned CNT_W        = PDL_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              alarm_clr_i,
    output logic [NUM_CH-1:0] toggle_o,
    output logic [NUM_CH-1:0] delay_line_o,
    output logic [NUM_CH-1:0] alarm_raw_o,
    output logic [NUM_CH-1:0] alarm_ch_o,
    output logic              alarm_o,
    output logic [CNT_W-1:0]  event_cnt_o
);

    localparam int unsigned BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [BLANK_W-1:0] blank_q, blank_d;
    logic               blank_done;
    logic [NUM_CH-1:0]  mis_vec, set_vec, qual;
    logic [NUM_CH-1:0]  alarm_q, alarm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    for (genvar c = 0; c < int'(NUM_CH); c++) begin : gen_ch
        cv32e40p_pdl_channel #(
            .THRESH (THRESH)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .en_i         (ch_en_i[c]),
            .blank_done_i (blank_done),
            .toggle_o     (toggle_o[c]),
            .delay_line_o (delay_line_o[c]),
            .mis_c_o      (mis_vec[c]),
            .set_c_o      (set_vec[c])
        );
    end

    // Blanking countdown, qualification, sticky alarms and saturating event count
    always_comb begin
        blank_done = (blank_q == '0);
        blank_d    = blank_done ? '0 : blank_q - BLANK_W'(1);
        qual       = mis_vec & ch_en_i & {NUM_CH{blank_done}};
        alarm_d    = set_vec | (alarm_q & {NUM_CH{~alarm_clr_i}});
        cnt_d      = cnt_q;
        if (alarm_clr_i) begin
            cnt_d = (|qual) ? CNT_W'(1) : '0;
        end else if (|qual) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
        end
    end

    // Monitor state registers; reset restarts the blanking window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= BLANK_W'(BLANK_CYCLES);
            alarm_q <= '0;
            cnt_q   <= '0;
        end else begin
            blank_q <= blank_d;
            alarm_q <= alarm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alarm_raw_o = qual;
    assign alarm_ch_o  = alarm_q;
    assign alarm_o     = |alarm_q;
    assign event_cnt_o = cnt_q;

endmodule

// File: tb/tb_cv32e40p_pdl_monitor.sv
// Directed bench for the PDL glitch monitor; glitches modelled by forcing delay-line outputs.
module tb_cv32e40p_pdl_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ch_en_i = 4'hF;
    logic       alarm_clr_i = 1'b0;

    logic [3:0] toggle_o, delay_line_o, alarm_raw_o, alarm_ch_o;
    logic       alarm_o;
    logic [7:0] event_cnt_o;

    logic [3:0] c3_toggle_o, c3_delay_line_o, c3_alarm_raw_o, c3_alarm_ch_o;
    logic       c3_alarm_o;
    logic [2:0] c3_event_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference toggle value shared by all channels of both instances
    logic tog_e = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) tog_e <= rst_n ? ~tog_e : 1'b0;

    cv32e40p_pdl_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en_i      (ch_en_i),
        .alarm_clr_i  (alarm_clr_i),
        .toggle_o     (toggle_o),
        .delay_line_o (delay_line_o),
        .alarm_raw_o  (alarm_raw_o),
        .alarm_ch_o   (alarm_ch_o),
        .alarm_o      (alarm_o),
        .event_cnt_o  (event_cnt_o)
    );

    cv32e40p_pdl_monitor #(.CNT_W(3)) dut_c3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en_i      (ch_en_i),
        .alarm_clr_i  (alarm_clr_i),
        .toggle_o     (c3_toggle_o),
        .delay_line_o (c3_delay_line_o),
        .alarm_raw_o  (c3_alarm_raw_o),
        .alarm_ch_o   (c3_alarm_ch_o),
        .alarm_o      (c3_alarm_o),
        .event_cnt_o  (c3_event_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset for 3 cycles
        step(3);
        chk("rst_toggle", 32'(toggle_o), 32'h0);
        chk("rst_raw", 32'(alarm_raw_o), 32'h0);
        chk("rst_alarm_ch", 32'(alarm_ch_o), 32'h0);
        chk("rst_alarm", 32'(alarm_o), 32'h0);
        chk("rst_cnt", 32'(event_cnt_o), 32'h0);
        chk("rst_cnt_c3", 32'(c3_event_cnt_o), 32'h0);
        rst_n = 1'b1;

        // 1: nominal clock, no alarms, toggles alternate starting from 0
        for (int i = 1; i <= 200; i++) begin
            step(1);
            chk("nom_toggle", 32'(toggle_o), (i % 2 == 1) ? 32'hF : 32'h0);
            chk("nom_dline", 32'(delay_line_o), (i % 2 == 1) ? 32'hF : 32'h0);
            chk("nom_raw", 32'(alarm_raw_o), 32'h0);
        end
        chk("nom_alarm", 32'(alarm_o), 32'h0);
        chk("nom_cnt", 32'(event_cnt_o), 32'h0);

        // 2: single-cycle glitch on ch1 does not latch
        step(10);
        force dut.gen_ch[1].u_ch.delay_line_o = ~tog_e;
        step(1);
        release dut.gen_ch[1].u_ch.delay_line_o;
        chk("g1_raw", 32'(alarm_raw_o), 32'h2);
        step(1);
        chk("g1_raw_after", 32'(alarm_raw_o), 32'h0);
        chk("g1_alarm_ch", 32'(alarm_ch_o), 32'h0);
        chk("g1_cnt", 32'(event_cnt_o), 32'h1);
        step(3);
        // two consecutive glitch cycles latch ch1
        force dut.gen_ch[1].u_ch.delay_line_o = ~tog_e;
        step(1);
        chk("g2_raw_a", 32'(alarm_raw_o), 32'h2);
        force dut.gen_ch[1].u_ch.delay_line_o = ~tog_e;
        step(1);
        release dut.gen_ch[1].u_ch.delay_line_o;
        chk("g2_raw_b", 32'(alarm_raw_o), 32'h2);
        chk("g2_not_yet", 32'(alarm_ch_o), 32'h0);
        step(1);
        chk("g2_alarm_ch", 32'(alarm_ch_o), 32'h2);
        chk("g2_alarm", 32'(alarm_o), 32'h1);
        chk("g2_cnt", 32'(event_cnt_o), 32'h3);
        step(2);
        chk("g2_sticky", 32'(alarm_ch_o), 32'h2);

        // 4: clear, then latch ch2 and clear it without a mismatch
        alarm_clr_i = 1'b1;
        step(1);
        alarm_clr_i = 1'b0;
        chk("clr0_alarm_ch", 32'(alarm_ch_o), 32'h0);
        chk("clr0_cnt", 32'(event_cnt_o), 32'h0);
        force dut.gen_ch[2].u_ch.delay_line_o = ~tog_e;
        step(1);
        force dut.gen_ch[2].u_ch.delay_line_o = ~tog_e;
        step(1);
        release dut.gen_ch[2].u_ch.delay_line_o;
        step(1);
        chk("s2_alarm_ch", 32'(alarm_ch_o), 32'h4);
        chk("s2_cnt", 32'(event_cnt_o), 32'h2);
        alarm_clr_i = 1'b1;
        step(1);
        alarm_clr_i = 1'b0;
        chk("s2_clr_alarm_ch", 32'(alarm_ch_o), 32'h0);
        chk("s2_clr_alarm", 32'(alarm_o), 32'h0);
        chk("s2_clr_cnt", 32'(event_cnt_o), 32'h0);
        // clear on the latch cycle: set wins, counter restarts at 1
        force dut.gen_ch[2].u_ch.delay_line_o = ~tog_e;
        step(1);
        force dut.gen_ch[2].u_ch.delay_line_o = ~tog_e;
        step(1);
        release dut.gen_ch[2].u_ch.delay_line_o;
        alarm_clr_i = 1'b1;
        step(1);
        alarm_clr_i = 1'b0;
        chk("s2_setwins_ch", 32'(alarm_ch_o), 32'h4);
        chk("s2_setwins_cnt", 32'(event_cnt_o), 32'h1);

        // 5: ch0 disabled while glitching, then enabled mid-run
        alarm_clr_i = 1'b1;
        step(1);
        alarm_clr_i = 1'b0;
        ch_en_i = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            force dut.gen_ch[0].u_ch.delay_line_o = ~tog_e;
            step(1);
            chk("dis_raw", 32'(alarm_raw_o), 32'h0);
        end
        chk("dis_alarm_ch", 32'(alarm_ch_o), 32'h0);
        chk("dis_cnt", 32'(event_cnt_o), 32'h0);
        ch_en_i = 4'hF;
        #1;
        chk("en_raw_a", 32'(alarm_raw_o), 32'h1);
        force dut.gen_ch[0].u_ch.delay_line_o = ~tog_e;
        step(1);
        release dut.gen_ch[0].u_ch.delay_line_o;
        chk("en_raw_b", 32'(alarm_raw_o), 32'h1);
        chk("en_not_yet", 32'(alarm_ch_o), 32'h0);
        step(1);
        chk("en_alarm_ch", 32'(alarm_ch_o), 32'h1);
        chk("en_cnt", 32'(event_cnt_o), 32'h2);

        // 3: reset mid-run, glitches inside the blanking window are ignored
        rst_n = 1'b0;
        step(2);
        chk("rst2_alarm_ch", 32'(alarm_ch_o), 32'h0);
        chk("rst2_cnt", 32'(event_cnt_o), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            force dut.gen_ch[0].u_ch.delay_line_o = ~tog_e;
            force dut.gen_ch[3].u_ch.delay_line_o = ~tog_e;
            step(1);
            chk("blank_raw", 32'(alarm_raw_o), 32'h0);
        end
        release dut.gen_ch[0].u_ch.delay_line_o;
        release dut.gen_ch[3].u_ch.delay_line_o;
        step(1);
        chk("blank_cnt", 32'(event_cnt_o), 32'h0);
        chk("blank_alarm", 32'(alarm_o), 32'h0);
        force dut.gen_ch[3].u_ch.delay_line_o = ~tog_e;
        step(1);
        release dut.gen_ch[3].u_ch.delay_line_o;
        chk("post_blank_raw", 32'(alarm_raw_o), 32'h8);
        step(1);
        chk("post_blank_cnt", 32'(event_cnt_o), 32'h1);

        // 6: 3-bit counter saturates at 7, then reset mid-run clears everything
        alarm_clr_i = 1'b1;
        step(1);
        alarm_clr_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            force dut_c3.gen_ch[0].u_ch.delay_line_o = ~tog_e;
            step(1);
            chk("sat_cnt", 32'(c3_event_cnt_o), (i - 1 < 7) ? 32'(i - 1) : 32'd7);
        end
        chk("sat_alarm_ch", 32'(c3_alarm_ch_o), 32'h1);
        chk("sat_raw", 32'(c3_alarm_raw_o), 32'h1);
        rst_n = 1'b0;
        step(1);
        chk("midrst_toggle", 32'(c3_toggle_o), 32'h0);
        chk("midrst_raw", 32'(c3_alarm_raw_o), 32'h0);
        chk("midrst_alarm_ch", 32'(c3_alarm_ch_o), 32'h0);
        chk("midrst_alarm", 32'(c3_alarm_o), 32'h0);
        chk("midrst_cnt", 32'(c3_event_cnt_o), 32'h0);
        chk("midrst_cnt_main", 32'(event_cnt_o), 32'h0);
        release dut_c3.gen_ch[0].u_ch.delay_line_o;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
